// File: rtl/logic_clock_domain_crossing_read_arbiter.sv
// Packet-level round-robin arbiter that merges the read sides of several
// CDC FIFOs onto one AXI4-Stream sink, tagging each beat with its source
// channel on tx_tid.

// Per-channel slice: decodes the grant, gates this channel's ready and
// masks its payload so the top can OR-reduce the selected beat.
module logic_clock_domain_crossing_read_arbiter_lane #(
  parameter int IDX        = 0,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic [ID_WIDTH-1:0]   grant,
  input  logic                  open,
  input  logic                  valid,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  sel_valid,
  output logic                  sel_last,
  output logic [DATA_WIDTH-1:0] sel_data
);
  logic hit;

  assign hit       = (grant == ID_WIDTH'(IDX));
  assign ready     = hit & open;
  assign sel_valid = hit & valid;
  assign sel_last  = hit & last;
  assign sel_data  = hit ? data : '0;
endmodule

module logic_clock_domain_crossing_read_arbiter #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           aclk,
  input  logic                           areset_n,
  input  logic [CHANNELS-1:0]            rx_tvalid,
  input  logic [CHANNELS-1:0]            rx_tlast,
  input  logic [CHANNELS*DATA_WIDTH-1:0] rx_tdata,
  output logic [CHANNELS-1:0]            rx_tready,
  output logic                           tx_tvalid,
  output logic                           tx_tlast,
  output logic [DATA_WIDTH-1:0]          tx_tdata,
  output logic [ID_WIDTH-1:0]            tx_tid,
  input  logic                           tx_tready
);
  generate
    if (CHANNELS < 1)   begin : g_drc_ch $error("CHANNELS must be >= 1");   end
    if (DATA_WIDTH < 1) begin : g_drc_dw $error("DATA_WIDTH must be >= 1"); end
  endgenerate

  // Reset value of last_grant makes channel 0 the first winner.
  localparam logic [ID_WIDTH-1:0] LAST_CH = ID_WIDTH'(CHANNELS - 1);

  typedef enum logic {FSM_IDLE = 1'b0, FSM_LOCKED = 1'b1} fsm_state_t;

  fsm_state_t                          fsm_state, fsm_next;
  logic [ID_WIDTH-1:0]                 grant, grant_next, last_grant, last_grant_next;
  logic [ID_WIDTH-1:0]                 rr_pick, pick_hi, pick_lo;
  logic                                found_hi;
  logic                                load, open, transfer;
  logic [CHANNELS-1:0]                 lane_valid, lane_last;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] lane_data;
  logic                                sel_valid, sel_last;
  logic [DATA_WIDTH-1:0]               sel_data;

  // Output register accepts a new beat when empty or being drained.
  assign load     = !tx_tvalid || tx_tready;
  assign open     = (fsm_state == FSM_LOCKED) && load;
  assign transfer = open && sel_valid;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      logic_clock_domain_crossing_read_arbiter_lane #(
        .IDX(i), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)
      ) u_lane (
        .grant     (grant),
        .open      (open),
        .valid     (rx_tvalid[i]),
        .last      (rx_tlast[i]),
        .data      (rx_tdata[i*DATA_WIDTH +: DATA_WIDTH]),
        .ready     (rx_tready[i]),
        .sel_valid (lane_valid[i]),
        .sel_last  (lane_last[i]),
        .sel_data  (lane_data[i])
      );
    end
  endgenerate

  // Only the granted lane is non-zero, so OR-reduction acts as the mux.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_valid |= lane_valid[i];
      sel_last  |= lane_last[i];
      sel_data  |= lane_data[i];
    end
  end

  // Round-robin: lowest requester above last_grant, else lowest overall.
  // Descending scan so the final write is the lowest matching index.
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rx_tvalid[i]) begin
        if (ID_WIDTH'(i) > last_grant) begin
          pick_hi  = ID_WIDTH'(i);
          found_hi = 1'b1;
        end else begin
          pick_lo = ID_WIDTH'(i);
        end
      end
    end
    rr_pick = found_hi ? pick_hi : pick_lo;
  end

  // Next-state: arbitrate in IDLE, hold the grant until tlast is accepted.
  always_comb begin
    fsm_next        = fsm_state;
    grant_next      = grant;
    last_grant_next = last_grant;
    case (fsm_state)
      FSM_IDLE: begin
        if (|rx_tvalid) begin
          grant_next = rr_pick;
          fsm_next   = FSM_LOCKED;
        end
      end
      FSM_LOCKED: begin
        if (transfer && sel_last) begin
          last_grant_next = grant;
          fsm_next        = FSM_IDLE;
        end
      end
      default: fsm_next = FSM_IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      fsm_state  <= FSM_IDLE;
      grant      <= '0;
      last_grant <= LAST_CH;
    end else begin
      fsm_state  <= fsm_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
    end
  end

  // Output stage control: holds everything while the sink stalls.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      tx_tvalid <= 1'b0;
      tx_tlast  <= 1'b0;
      tx_tid    <= '0;
    end else if (load) begin
      tx_tvalid <= transfer;
      if (transfer) begin
        tx_tlast <= sel_last;
        tx_tid   <= grant;
      end
    end
  end

  // Output data path, left unreset since tx_tvalid qualifies it.
  always_ff @(posedge aclk) begin
    if (load && transfer) tx_tdata <= sel_data;
  end

`ifdef OVL_ASSERT_ON
  a_ready_onehot: assert property (@(posedge aclk) disable iff (!areset_n)
    $onehot0(rx_tready));
  a_tx_stable: assert property (@(posedge aclk) disable iff (!areset_n)
    (tx_tvalid && !tx_tready) |=> $stable({tx_tdata, tx_tlast, tx_tid}));
`endif
endmodule

// File: tb/tb_logic_clock_domain_crossing_read_arbiter.sv
// Directed + randomized bench: per-channel source queues feed the arbiter,
// and a scoreboard of queued beats per channel checks every output beat.
module tb_logic_clock_domain_crossing_read_arbiter;
  localparam int CH = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic              aclk = 1'b0;
  logic              areset_n = 1'b1;
  logic [CH-1:0]     rx_tvalid = '0, rx_tlast = '0, rx_tready;
  logic [CH*DW-1:0]  rx_tdata = '0;
  logic              tx_tvalid, tx_tlast, tx_tready = 1'b0;
  logic [DW-1:0]     tx_tdata;
  logic [IW-1:0]     tx_tid;

  logic_clock_domain_crossing_read_arbiter #(.CHANNELS(CH), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tdata(rx_tdata), .rx_tready(rx_tready),
    .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tdata(tx_tdata), .tx_tid(tx_tid),
    .tx_tready(tx_tready)
  );

  always #5 aclk = ~aclk;

  typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;
  typedef struct { int cyc; int tid; logic [DW-1:0] d; logic l; logic [CH-1:0] rdy; } log_t;

  beat_t srcq[CH][$];
  beat_t expq[CH][$];
  log_t  txlog[$];

  int            n_assert = 0, n_fail = 0, cyc = 0, start = 0;
  int            tr_mode = 0, hook = 0, drop = 0, pkt_tid = 0;
  logic [CH-1:0] en = '0, forbid = '0;
  logic          in_pkt = 1'b0, prev_stall = 1'b0, p_l = 1'b0;
  logic [DW-1:0] p_d = '0;
  logic [IW-1:0] p_id = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int c = 0; c < CH; c++) s += expq[c].size();
    return s;
  endfunction

  task automatic push_beat(input int c, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    srcq[c].push_back(b);
    expq[c].push_back(b);
  endtask

  task automatic send(input int c, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) push_beat(c, base + 8'(k), k == n - 1);
  endtask

  // Asserts reset off the clock edge and checks outputs before any edge.
  task automatic do_reset();
    areset_n = 1'b0;
    rx_tvalid = '0; rx_tlast = '0; rx_tdata = '0; tx_tready = 1'b0;
    #1;
    chk("rst_tvalid", tx_tvalid, 0);
    chk("rst_tlast", tx_tlast, 0);
    chk("rst_tid", tx_tid, 0);
    chk("rst_rready", rx_tready, 0);
    for (int c = 0; c < CH; c++) begin srcq[c].delete(); expq[c].delete(); end
    txlog.delete();
    in_pkt = 1'b0; prev_stall = 1'b0; forbid = '0; hook = 0; drop = 0;
    repeat (2) @(posedge aclk);
    #1 areset_n = 1'b1;
  endtask

  // One cycle: drive at edge+1, check at edge+2, commit handshakes at the edge.
  task automatic step();
    int            t;
    beat_t         e;
    logic [CH-1:0] rx_hs;
    case (hook)
      1: begin
        forbid = (srcq[0].size() > 0) ? 4'b0010 : 4'b0000;
        if (txlog.size() >= 1) en[1] = 1'b1;
      end
      2: begin
        forbid = (srcq[3].size() > 0) ? 4'b0001 : 4'b0000;
        if (txlog.size() >= 1) en[0] = 1'b1;
        if (txlog.size() >= 1 && drop < 3) begin en[3] = 1'b0; drop++; end
        else en[3] = 1'b1;
      end
      3: en = 4'($urandom);
      default: ;
    endcase
    for (int c = 0; c < CH; c++) begin
      rx_tvalid[c] = en[c] && (srcq[c].size() > 0);
      rx_tlast[c] = 1'b0;
      rx_tdata[c*DW +: DW] = '0;
      if (rx_tvalid[c]) begin
        rx_tlast[c] = srcq[c][0].l;
        rx_tdata[c*DW +: DW] = srcq[c][0].d;
      end
    end
    case (tr_mode)
      0: tx_tready = 1'b1;
      1: tx_tready = (cyc % 3 == 0);
      default: tx_tready = 1'($urandom_range(0, 1));
    endcase
    #1;
    chk("rdy_onehot", $onehot0(rx_tready), 1);
    chk("rdy_forbid", rx_tready & forbid, 0);
    if (tx_tvalid && !tx_tready) chk("rdy_stall", rx_tready, 0);
    if (prev_stall) begin
      chk("stall_v", tx_tvalid, 1);
      chk("stall_d", tx_tdata, p_d);
      chk("stall_l", tx_tlast, p_l);
      chk("stall_id", tx_tid, p_id);
    end
    prev_stall = tx_tvalid && !tx_tready;
    p_d = tx_tdata; p_l = tx_tlast; p_id = tx_tid;
    if (tx_tvalid && tx_tready) begin
      t = int'(tx_tid);
      if (in_pkt) chk("no_interleave", t, pkt_tid);
      chk("tx_expected", expq[t].size() > 0, 1);
      if (expq[t].size() > 0) begin
        e = expq[t].pop_front();
        chk("tx_data", tx_tdata, e.d);
        chk("tx_last", tx_tlast, e.l);
      end
      in_pkt = !tx_tlast;
      pkt_tid = t;
      txlog.push_back('{cyc, t, tx_tdata, tx_tlast, rx_tready});
    end
    rx_hs = rx_tvalid & rx_tready;
    @(posedge aclk);
    for (int c = 0; c < CH; c++) if (rx_hs[c]) void'(srcq[c].pop_front());
    cyc++;
    #1;
  endtask

  task automatic run_until(input string tag, input int nlog, input int budget);
    int k = 0;
    while (txlog.size() < nlog && k < budget) begin step(); k++; end
    chk(tag, txlog.size() >= nlog, 1);
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (pending() > 0 && k < budget) begin step(); k++; end
    chk(tag, pending(), 0);
    repeat (3) step();
  endtask

  task automatic chk_tids(input string tag, input int n, input int tids[6]);
    chk({tag, "_count"}, txlog.size(), n);
    for (int k = 0; k < n && k < txlog.size(); k++) chk(tag, txlog[k].tid, tids[k]);
  endtask

  initial begin
    #2;
    // Channel 2 alone, 3-beat packet at full throughput.
    do_reset();
    en = '1; tr_mode = 0;
    push_beat(2, 8'h11, 1'b0); push_beat(2, 8'h22, 1'b0); push_beat(2, 8'h33, 1'b1);
    start = cyc;
    run_until("t1_timeout", 3, 20);
    if (txlog.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("t1_cyc", txlog[k].cyc - start, 2 + k);
        chk("t1_tid", txlog[k].tid, 2);
      end
      chk("t1_d0", txlog[0].d, 8'h11);
      chk("t1_l1", txlog[1].l, 0);
      chk("t1_l2", txlog[2].l, 1);
      chk("t1_rdy_locked", txlog[0].rdy, 4'b0100);
      chk("t1_rdy_idle", txlog[2].rdy, 4'b0000);
    end
    drain("t1_drain", 10);

    // All channels with 1-beat packets: strict rotation, one beat per 2 cycles.
    do_reset();
    en = '1; tr_mode = 0;
    for (int p = 0; p < 2; p++) for (int c = 0; c < CH; c++) send(c, 1, 8'(16 * c + p));
    start = cyc;
    run_until("t2_timeout", 6, 40);
    for (int k = 0; k < 6 && k < txlog.size(); k++) begin
      chk("t2_tid", txlog[k].tid, k % 4);
      chk("t2_cyc", txlog[k].cyc - start, 2 + 2 * k);
    end
    drain("t2_drain", 20);

    // Channel 1 arrives mid-packet of channel 0; then repeat with sink stalls.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      en = 4'b0001; tr_mode = pass; hook = 1;
      send(0, 4, 8'hC0);
      send(1, 2, 8'hD0);
      drain(pass == 0 ? "t3_drain" : "t4_drain", 60);
      chk_tids(pass == 0 ? "t3_tid" : "t4_tid", 6, '{0, 0, 0, 0, 1, 1});
    end

    // Channel 3 drops valid mid-packet while channel 0 waits.
    do_reset();
    en = 4'b1000; tr_mode = 0; hook = 2;
    send(3, 3, 8'h30);
    send(0, 2, 8'h70);
    drain("t5_drain", 40);
    chk_tids("t5_tid", 5, '{3, 3, 3, 0, 0, 0});

    // Reset during beat 2 of a channel 1 packet, then channel 0 wins first.
    do_reset();
    en = 4'b0010; tr_mode = 0;
    send(1, 4, 8'h90);
    run_until("t6_timeout", 1, 20);
    do_reset();
    en = '1; tr_mode = 0;
    send(1, 1, 8'h5A);
    send(0, 1, 8'hA5);
    start = cyc;
    run_until("t6_timeout2", 1, 10);
    if (txlog.size() >= 1) begin
      chk("t6_first_tid", txlog[0].tid, 0);
      chk("t6_first_cyc", txlog[0].cyc - start, 2);
    end
    drain("t6_drain", 20);

    // Random packets, random valid gaps and random sink backpressure.
    do_reset();
    tr_mode = 2; hook = 3;
    for (int p = 0; p < 6; p++)
      for (int c = 0; c < CH; c++) begin
        int n = int'($urandom_range(1, 4));
        for (int k = 0; k < n; k++) push_beat(c, 8'($urandom), k == n - 1);
      end
    drain("rand_drain", 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
